// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and the digit-to-segment lookup for the
// multiplexed HH:MM seven-segment display.
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_ALL_OFF = 4'hF;

  localparam logic [1:0] DIG_MIN_ONES = 2'd0;
  localparam logic [1:0] DIG_MIN_TENS = 2'd1;
  localparam logic [1:0] DIG_HR_ONES  = 2'd2;
  localparam logic [1:0] DIG_HR_TENS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    CONV_HR,
    CONV_MIN,
    COMMIT
  } upd_state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] pat;
    pat = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (nib == 4'(i)) pat = SEG_DIGIT[i];
    end
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter (double dabble).
// One start pulse, six shift cycles, then a one-cycle done pulse.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // {tens, ones, remaining binary bits}
  logic [13:0] shreg;
  logic [2:0]  step;

  function automatic logic [13:0] dabble(input logic [13:0] s);
    logic [13:0] a;
    a = s;
    if (a[9:6]   >= 4'd5) a[9:6]   = a[9:6]   + 4'd3;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    return {a[12:0], 1'b0};
  endfunction

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      shreg <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        shreg <= {8'b0, bin};
        step  <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        shreg <= dabble(shreg);
        if (step == 3'd5) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          step <= step + 3'd1;
        end
      end
    end
  end

  assign tens = shreg[13:10];
  assign ones = shreg[9:6];

endmodule

// File: rtl/seg7_clock_display.sv
// Display end of the binary clock: synchronises hours/minutes, converts them
// to BCD once per scan frame and multiplexes four common-anode digits.
module seg7_clock_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DIGIT_HZ        = 1_000,
  parameter bit BLANK_LEAD_ZERO = 1'b1
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic       sig_1Hz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CW    = $clog2(DWELL);

  logic [3:0] hours_meta, hours_sync;
  logic [5:0] minutes_meta, minutes_sync;
  logic       sig_meta, sig_sync;

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      hours_meta   <= '0;
      hours_sync   <= '0;
      minutes_meta <= '0;
      minutes_sync <= '0;
      sig_meta     <= 1'b0;
      sig_sync     <= 1'b0;
    end else begin
      hours_meta   <= hours;
      hours_sync   <= hours_meta;
      minutes_meta <= minutes;
      minutes_sync <= minutes_meta;
      sig_meta     <= sig_1Hz;
      sig_sync     <= sig_meta;
    end
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          dwell_end, frame_start;

  assign dwell_end   = (cnt == CW'(DWELL - 1));
  assign frame_start = dwell_end && (idx == DIG_HR_TENS);

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      cnt <= '0;
      idx <= DIG_MIN_ONES;
    end else if (dwell_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  upd_state_t state;
  logic       conv_start, conv_busy, conv_done;
  logic [5:0] conv_bin;
  logic [3:0] conv_tens, conv_ones;
  logic [3:0] hr_snap, hr_tens, hr_ones, min_tens, min_ones;
  logic [5:0] min_snap;
  logic [3:0] disp [4];
  logic       lead_shown;

  assign conv_bin = (state == CONV_MIN) ? min_snap : {2'b00, hr_snap};

  bin2bcd_seq u_bin2bcd (
    .clk_100Mhz (clk_100Mhz),
    .reset      (reset),
    .start      (conv_start),
    .bin        (conv_bin),
    .busy       (conv_busy),
    .done       (conv_done),
    .tens       (conv_tens),
    .ones       (conv_ones)
  );

  // NOTE: the display nibbles are a handful of flops, not a RAM, so they
  // are reset explicitly; nothing stale survives a reset mid-conversion.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state      <= IDLE;
      conv_start <= 1'b0;
      hr_snap    <= '0;
      min_snap   <= '0;
      hr_tens    <= '0;
      hr_ones    <= '0;
      min_tens   <= '0;
      min_ones   <= '0;
      lead_shown <= 1'b0;
      for (int i = 0; i < 4; i++) disp[i] <= '0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        IDLE: if (frame_start) state <= SNAP;
        SNAP: begin
          hr_snap    <= hours_sync;
          min_snap   <= minutes_sync;
          conv_start <= 1'b1;
          state      <= CONV_HR;
        end
        CONV_HR: if (conv_done) begin
          hr_tens    <= conv_tens;
          hr_ones    <= conv_ones;
          conv_start <= 1'b1;
          state      <= CONV_MIN;
        end
        CONV_MIN: if (conv_done) begin
          min_tens <= conv_tens;
          min_ones <= conv_ones;
          state    <= COMMIT;
        end
        COMMIT: begin
          // All four digits change together so a frame never shows a torn time.
          disp[DIG_MIN_ONES] <= min_ones;
          disp[DIG_MIN_TENS] <= min_tens;
          disp[DIG_HR_ONES]  <= hr_ones;
          disp[DIG_HR_TENS]  <= hr_tens;
          lead_shown         <= !(BLANK_LEAD_ZERO && (hr_tens == 4'd0));
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [6:0] pattern;

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    pattern = seg_of(disp[idx]);
    if (idx == DIG_HR_TENS && !lead_shown) pattern = SEG_BLANK;
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset || cnt == '0) begin
      // First cycle of each dwell is dark so the previous digit cannot ghost.
      an  <= AN_ALL_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= pattern;
      dp  <= ~((idx == DIG_HR_ONES) && sig_sync);
    end
  end

  frame_in_idle: assert property (@(posedge clk_100Mhz) disable iff (reset)
    frame_start |-> (state == IDLE));

  start_when_free: assert property (@(posedge clk_100Mhz) disable iff (reset)
    conv_start |-> !conv_busy);

endmodule

// File: tb/tb_seg7_clock_display.sv
// Randomised bench for seg7_clock_display; expected outputs come from an
// arithmetic model of scan position, frame snapshot time and decimal digits.
module tb_seg7_clock_display;

  localparam int DWELL      = 40;
  localparam int FRAME      = 4 * DWELL;
  localparam int COMMIT_LAT = 18;
  localparam int SYNC_LAT   = 2;
  // First scan position showing a committed value, and the input edge it samples.
  localparam int FIRST_VIS  = (FRAME - 1) + COMMIT_LAT + 1;
  localparam int SNAP_SRC   = (FRAME - 1) + 1 - SYNC_LAT;
  localparam int HMAX       = 8192;

  localparam logic [6:0] TB_SEG [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic       clk;
  logic       reset;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       sig_1Hz;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;
  logic [3:0] an, an_nb;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int cur_p = -1;
  int hr_h [HMAX];
  int mn_h [HMAX];
  int sg_h [HMAX];

  seg7_clock_display #(.CLK_HZ(40_000), .DIGIT_HZ(1_000), .BLANK_LEAD_ZERO(1'b1)) dut (
    .clk_100Mhz (clk), .reset (reset), .hours (hours), .minutes (minutes),
    .sig_1Hz (sig_1Hz), .seg (seg), .dp (dp), .an (an)
  );

  seg7_clock_display #(.CLK_HZ(40_000), .DIGIT_HZ(1_000), .BLANK_LEAD_ZERO(1'b0)) dut_nb (
    .clk_100Mhz (clk), .reset (reset), .hours (hours), .minutes (minutes),
    .sig_1Hz (sig_1Hz), .seg (seg_nb), .dp (dp_nb), .an (an_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, log what the DUT sampled, return on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      k     = 0;
      cur_p = -1;
    end else begin
      if (k >= HMAX) begin
        $display("FAIL history_overflow got=%0d want<%0d", k, HMAX);
        $fatal(1, "history overflow");
      end
      hr_h[k] = int'(hours);
      mn_h[k] = int'(minutes);
      sg_h[k] = int'(sig_1Hz);
      cur_p   = k;
      k++;
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] exp_an(input int p);
    if (p % DWELL == 0) return 4'hF;
    return ~(4'b0001 << ((p / DWELL) % 4));
  endfunction

  function automatic logic exp_dp(input int p);
    int sync_sig;
    if (p % DWELL == 0) return 1'b1;
    sync_sig = (p >= SYNC_LAT) ? sg_h[p - SYNC_LAT] : 0;
    return !(((p / DWELL) % 4) == 2 && sync_sig != 0);
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input bit blz);
    int h, mn, v, src, idx;
    bit lead_blank;
    h = 0; mn = 0; v = 0; lead_blank = 1'b1;
    idx = (p / DWELL) % 4;
    if (p % DWELL == 0) return 7'h7F;
    if (p >= FIRST_VIS) begin
      src        = ((p - FIRST_VIS) / FRAME) * FRAME + SNAP_SRC;
      h          = hr_h[src];
      mn         = mn_h[src];
      lead_blank = blz && (h / 10 == 0);
    end
    case (idx)
      0:       v = mn % 10;
      1:       v = mn / 10;
      2:       v = h % 10;
      default: begin
        if (lead_blank) return 7'h7F;
        v = h / 10;
      end
    endcase
    return TB_SEG[v];
  endfunction

  function automatic logic [23:0] exp_vec(input int p);
    return {exp_an(p), exp_dp(p), exp_seg(p, 1'b1), exp_an(p), exp_dp(p), exp_seg(p, 1'b0)};
  endfunction

  // seg is only meaningful while a digit is lit, so it is masked on dark cycles.
  function automatic logic [23:0] obs_vec();
    bit dark;
    dark = (cur_p % DWELL == 0);
    return {an, dp, dark ? 7'h7F : seg, an_nb, dp_nb, dark ? 7'h7F : seg_nb};
  endfunction

  task automatic test_reset();
    reset = 1'b1; hours = 4'd0; minutes = 6'd0; sig_1Hz = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({an, seg, dp, an_nb, seg_nb, dp_nb} !== {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1}) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                 c, an, seg, dp);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < FRAME + 40; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec(cur_p)) begin
        bad++;
        $display("FAIL reset_first_frame p=%0d got=%h want=%h", cur_p, obs_vec(), exp_vec(cur_p));
      end
    end
  endtask

  task automatic test_fixed();
    int tbl_h [4] = '{9, 12, 15, 3};
    int tbl_m [4] = '{37, 5, 63, 0};
    for (int t = 0; t < 4; t++) begin
      hours   = 4'(tbl_h[t]);
      minutes = 6'(tbl_m[t]);
      for (int c = 0; c < 2 * FRAME; c++) begin
        tick();
        total++;
        if (obs_vec() !== exp_vec(cur_p)) begin
          bad++;
          $display("FAIL fixed_%0d_%0d p=%0d got=%h want=%h",
                   tbl_h[t], tbl_m[t], cur_p, obs_vec(), exp_vec(cur_p));
        end
      end
    end
  endtask

  task automatic test_colon();
    hours = 4'd10; minutes = 6'd59;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if ($urandom_range(0, 5) == 0) sig_1Hz = ~sig_1Hz;
      tick();
      total++;
      if (obs_vec() !== exp_vec(cur_p)) begin
        bad++;
        $display("FAIL colon p=%0d got=%h want=%h", cur_p, obs_vec(), exp_vec(cur_p));
      end
    end
  endtask

  task automatic test_midframe();
    int chg;
    for (int it = 0; it < 4; it++) begin
      chg = int'($urandom_range(1, 2 * FRAME));
      for (int c = 0; c < 3 * FRAME; c++) begin
        if (c == chg) begin
          minutes = 6'($urandom_range(0, 63));
          hours   = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 31) == 0) sig_1Hz = ~sig_1Hz;
        tick();
        total++;
        if (obs_vec() !== exp_vec(cur_p)) begin
          bad++;
          $display("FAIL midframe it=%0d p=%0d got=%h want=%h", it, cur_p, obs_vec(), exp_vec(cur_p));
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    bit found;
    found = 1'b0;
    hours = 4'd14; minutes = 6'd52;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec(cur_p)) begin
        bad++;
        $display("FAIL pre_abort p=%0d got=%h want=%h", cur_p, obs_vec(), exp_vec(cur_p));
      end
      // Position 10 of a frame: the next edge lands 12 cycles past frame_start.
      if (cur_p >= FRAME && cur_p % FRAME == 10) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_window got=not_reached want=reached");
    end
    reset = 1'b1;
    tick();
    total++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      bad++;
      $display("FAIL abort_blank got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    reset = 1'b0;
    hours = 4'd7; minutes = 6'd21;
    for (int c = 0; c < FRAME + 80; c++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec(cur_p)) begin
        bad++;
        $display("FAIL post_abort p=%0d got=%h want=%h", cur_p, obs_vec(), exp_vec(cur_p));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6 * FRAME; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        hours   = 4'($urandom_range(0, 15));
        minutes = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) sig_1Hz = ~sig_1Hz;
      tick();
      total++;
      if (obs_vec() !== exp_vec(cur_p)) begin
        bad++;
        $display("FAIL random p=%0d got=%h want=%h", cur_p, obs_vec(), exp_vec(cur_p));
      end
    end
  endtask

  initial begin
    reset = 1'b1; hours = '0; minutes = '0; sig_1Hz = 1'b0;
    test_reset();
    test_fixed();
    test_colon();
    test_midframe();
    test_reset_mid_conv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
